// File: rtl/risc_pkg.sv
// Shared encodings and types for the RISC pipeline back end.
package risc_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [4:0] FS_MOV = 5'b00000;
    localparam logic [4:0] FS_JML = 5'b11100;
    localparam logic [4:0] FS_MUL = 5'b11110;
    localparam logic [4:0] FS_MUI = 5'b11111;

    localparam logic [1:0] MD_ALU = 2'b00;
    localparam logic [1:0] MD_MEM = 2'b01;
    localparam logic [1:0] MD_SLT = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MUL_LO = 2'b01,
        MUL_HI = 2'b10
    } wb_state_t;

    // MUL and MUI share the upper four function-select bits.
    function automatic logic is_mul(input logic [4:0] fs);
        return (fs[4:1] == FS_MUL[4:1]);
    endfunction

endpackage

// File: rtl/ex_wb_stage_mux.sv
// Write-back source select: ALU result, load data or set-less-than bit.
module wb_data_mux
    import risc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [1:0]        md,
    input  logic [DATA_W-1:0] f,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              n_in,
    input  logic              v_in,
    output logic [DATA_W-1:0] wd_s
);

    // Reserved encoding writes zero.
    always_comb begin
        wd_s = {DATA_W{1'b0}};
        case (md)
            MD_ALU:  wd_s = f;
            MD_MEM:  wd_s = mem_data;
            MD_SLT:  wd_s = {{(DATA_W-1){1'b0}}, n_in ^ v_in};
            default: wd_s = {DATA_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/ex_wb_stage.sv
// Execute-to-writeback stage: registers ALU results, drives the register-file
// write port, splits 64-bit products into two writes and holds the PSR.
module ex_wb_stage
    import risc_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int HI_OFFSET = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_in,
    input  logic [4:0]          FS,
    input  logic [DATA_W-1:0]   F,
    input  logic [2*DATA_W-1:0] F_mul,
    input  logic                Z_in,
    input  logic                C_in,
    input  logic                N_in,
    input  logic                V_in,
    input  logic [ADDR_W-1:0]   DA,
    input  logic                RW,
    input  logic [1:0]          MD,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                stall,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_wa,
    output logic [DATA_W-1:0]   rf_wd,
    output logic [3:0]          psr,
    output logic                valid_out
);

    localparam logic [ADDR_W-1:0] HI_OFF_C = ADDR_W'(HI_OFFSET);
    localparam logic [ADDR_W-1:0] R0_C     = {ADDR_W{1'b0}};

    wb_state_t           state_r;
    wb_state_t           state_s;
    logic                accept_s;
    logic                mul_s;
    logic [DATA_W-1:0]   sel_wd_s;
    logic [DATA_W-1:0]   hi_wd_r;
    logic [ADDR_W-1:0]   hi_wa_r;
    logic                hi_rw_r;
    logic                rf_we_r;
    logic [ADDR_W-1:0]   rf_wa_r;
    logic [DATA_W-1:0]   rf_wd_r;
    logic [3:0]          psr_r;
    logic                valid_out_r;

    wb_data_mux #(.DATA_W(DATA_W)) u_mux (
        .md       (MD),
        .f        (F),
        .mem_data (mem_data),
        .n_in     (N_in),
        .v_in     (V_in),
        .wd_s     (sel_wd_s)
    );

    // stall decodes state only so no loop forms through upstream valid_in.
    assign stall    = (state_r == MUL_LO);
    assign accept_s = valid_in && !stall;
    assign mul_s    = is_mul(FS);

    // Next-state decode.
    always_comb begin
        state_s = IDLE;
        case (state_r)
            IDLE, MUL_HI: begin
                if (accept_s && mul_s) begin
                    state_s = MUL_LO;
                end else begin
                    state_s = IDLE;
                end
            end
            MUL_LO:  state_s = MUL_HI;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Write-port, PSR and pending high-word registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we_r     <= 1'b0;
            rf_wa_r     <= R0_C;
            rf_wd_r     <= {DATA_W{1'b0}};
            psr_r       <= 4'b0000;
            valid_out_r <= 1'b0;
            hi_wd_r     <= {DATA_W{1'b0}};
            hi_wa_r     <= R0_C;
            hi_rw_r     <= 1'b0;
        end else if (state_r == MUL_LO) begin
            rf_we_r     <= hi_rw_r && (hi_wa_r != R0_C);
            rf_wa_r     <= hi_wa_r;
            rf_wd_r     <= hi_wd_r;
            valid_out_r <= 1'b1;
        end else if (accept_s) begin
            psr_r   <= {Z_in, C_in, N_in, V_in};
            rf_wa_r <= DA;
            rf_we_r <= RW && (DA != R0_C);
            if (mul_s) begin
                rf_wd_r     <= F_mul[DATA_W-1:0];
                valid_out_r <= 1'b0;
                hi_wd_r     <= F_mul[2*DATA_W-1:DATA_W];
                hi_wa_r     <= DA + HI_OFF_C;
                hi_rw_r     <= RW;
            end else begin
                rf_wd_r     <= sel_wd_s;
                valid_out_r <= 1'b1;
            end
        end else begin
            rf_we_r     <= 1'b0;
            valid_out_r <= 1'b0;
        end
    end

    assign rf_we     = rf_we_r;
    assign rf_wa     = rf_wa_r;
    assign rf_wd     = rf_wd_r;
    assign psr       = psr_r;
    assign valid_out = valid_out_r;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed-vector bench for ex_wb_stage with hand-computed expectations.
module tb_ex_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [4:0]  FS;
    logic [31:0] F;
    logic [63:0] F_mul;
    logic        Z_in, C_in, N_in, V_in;
    logic [4:0]  DA;
    logic        RW;
    logic [1:0]  MD;
    logic [31:0] mem_data;
    logic        stall, rf_we, valid_out;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [3:0]  psr;

    int compared = 0;
    int mismatched = 0;

    ex_wb_stage dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .FS(FS), .F(F), .F_mul(F_mul),
        .Z_in(Z_in), .C_in(C_in), .N_in(N_in), .V_in(V_in), .DA(DA), .RW(RW), .MD(MD),
        .mem_data(mem_data), .stall(stall), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .psr(psr), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] zcnv);
        {Z_in, C_in, N_in, V_in} = zcnv;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_in = 1'b0; FS = 5'b00000; F = 32'h0; F_mul = 64'h0;
        set_flags(4'b1111); DA = 5'd9; RW = 1'b1; MD = 2'b00; mem_data = 32'h0;
        step(); step();
        compared++; if (rf_we !== 1'b0) begin mismatched++; $display("FAIL reset_we got %0h want 0", rf_we); end
        compared++; if (rf_wa !== 5'd0) begin mismatched++; $display("FAIL reset_wa got %0h want 0", rf_wa); end
        compared++; if (rf_wd !== 32'h0) begin mismatched++; $display("FAIL reset_wd got %0h want 0", rf_wd); end
        compared++; if (psr !== 4'b0000) begin mismatched++; $display("FAIL reset_psr got %0b want 0000", psr); end
        compared++; if (valid_out !== 1'b0) begin mismatched++; $display("FAIL reset_vout got %0h want 0", valid_out); end
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL reset_stall got %0h want 0", stall); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        valid_in = 1'b1; FS = 5'b00010; F = 32'h0000_0005; DA = 5'd3; RW = 1'b1; MD = 2'b00; set_flags(4'b0000);
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL add_stall_pre got %0h want 0", stall); end
        step();
        valid_in = 1'b0;
        compared++; if (rf_we !== 1'b1) begin mismatched++; $display("FAIL add_we got %0h want 1", rf_we); end
        compared++; if (rf_wa !== 5'd3) begin mismatched++; $display("FAIL add_wa got %0h want 3", rf_wa); end
        compared++; if (rf_wd !== 32'h5) begin mismatched++; $display("FAIL add_wd got %0h want 5", rf_wd); end
        compared++; if (valid_out !== 1'b1) begin mismatched++; $display("FAIL add_vout got %0h want 1", valid_out); end
        compared++; if (psr !== 4'b0000) begin mismatched++; $display("FAIL add_psr got %0b want 0000", psr); end
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL add_stall got %0h want 0", stall); end
        step();
        compared++; if (rf_we !== 1'b0) begin mismatched++; $display("FAIL bubble_we got %0h want 0", rf_we); end
        compared++; if (valid_out !== 1'b0) begin mismatched++; $display("FAIL bubble_vout got %0h want 0", valid_out); end
    endtask

    task automatic test_load_r0();
        valid_in = 1'b1; FS = 5'b00000; MD = 2'b01; mem_data = 32'hDEAD_BEEF; DA = 5'd0; RW = 1'b1; set_flags(4'b1000);
        step();
        valid_in = 1'b0;
        compared++; if (rf_we !== 1'b0) begin mismatched++; $display("FAIL load_r0_we got %0h want 0", rf_we); end
        compared++; if (valid_out !== 1'b1) begin mismatched++; $display("FAIL load_vout got %0h want 1", valid_out); end
        compared++; if (rf_wd !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL load_wd got %0h want deadbeef", rf_wd); end
        compared++; if (psr !== 4'b1000) begin mismatched++; $display("FAIL load_psr got %0b want 1000", psr); end
    endtask

    task automatic test_slt();
        valid_in = 1'b1; FS = 5'b00101; F = 32'hFFFF_FFFF; MD = 2'b10; DA = 5'd7; RW = 1'b1; set_flags(4'b0010);
        step();
        compared++; if (rf_wd !== 32'h1) begin mismatched++; $display("FAIL slt_nv10_wd got %0h want 1", rf_wd); end
        compared++; if (rf_we !== 1'b1 || rf_wa !== 5'd7) begin mismatched++; $display("FAIL slt_we_wa got %0h/%0h want 1/7", rf_we, rf_wa); end
        compared++; if (psr !== 4'b0010) begin mismatched++; $display("FAIL slt_psr got %0b want 0010", psr); end
        set_flags(4'b0011);
        step();
        valid_in = 1'b0;
        compared++; if (rf_wd !== 32'h0) begin mismatched++; $display("FAIL slt_nv11_wd got %0h want 0", rf_wd); end
        compared++; if (psr !== 4'b0011) begin mismatched++; $display("FAIL slt2_psr got %0b want 0011", psr); end
        MD = 2'b11; valid_in = 1'b1; set_flags(4'b0000);
        step();
        valid_in = 1'b0;
        compared++; if (rf_wd !== 32'h0 || rf_we !== 1'b1) begin mismatched++; $display("FAIL md_rsvd got %0h/%0h want 0/1", rf_wd, rf_we); end
        step();
    endtask

    task automatic test_mul_then_add();
        valid_in = 1'b1; FS = 5'b11110; F_mul = 64'h0000_0001_8000_0000; DA = 5'd4; RW = 1'b1; MD = 2'b01; set_flags(4'b0100);
        step();
        compared++; if (rf_wa !== 5'd4 || rf_wd !== 32'h8000_0000) begin mismatched++; $display("FAIL mul_lo got %0h/%0h want 4/80000000", rf_wa, rf_wd); end
        compared++; if (stall !== 1'b1 || rf_we !== 1'b1) begin mismatched++; $display("FAIL mul_lo_stall_we got %0h/%0h want 1/1", stall, rf_we); end
        compared++; if (valid_out !== 1'b0 || psr !== 4'b0100) begin mismatched++; $display("FAIL mul_lo_vout_psr got %0h/%0b want 0/0100", valid_out, psr); end
        FS = 5'b00010; F = 32'h0000_1234; DA = 5'd9; MD = 2'b00; set_flags(4'b1000);
        step();
        compared++; if (rf_wa !== 5'd5 || rf_wd !== 32'h1) begin mismatched++; $display("FAIL mul_hi got %0h/%0h want 5/1", rf_wa, rf_wd); end
        compared++; if (stall !== 1'b0 || valid_out !== 1'b1 || rf_we !== 1'b1) begin mismatched++; $display("FAIL mul_hi_ctl got %0h/%0h/%0h want 0/1/1", stall, valid_out, rf_we); end
        compared++; if (psr !== 4'b0100) begin mismatched++; $display("FAIL mul_hi_psr got %0b want 0100", psr); end
        step();
        valid_in = 1'b0;
        compared++; if (rf_wa !== 5'd9 || rf_wd !== 32'h1234 || rf_we !== 1'b1) begin mismatched++; $display("FAIL add_after_mul got %0h/%0h/%0h want 9/1234/1", rf_wa, rf_wd, rf_we); end
        compared++; if (psr !== 4'b1000 || valid_out !== 1'b1) begin mismatched++; $display("FAIL add_after_mul_psr got %0b/%0h want 1000/1", psr, valid_out); end
        step();
        compared++; if (rf_we !== 1'b0 || valid_out !== 1'b0) begin mismatched++; $display("FAIL add_once got %0h/%0h want 0/0", rf_we, valid_out); end
    endtask

    task automatic test_mul_wrap();
        valid_in = 1'b1; FS = 5'b11111; F_mul = 64'hAAAA_BBBB_CCCC_DDDD; DA = 5'd31; RW = 1'b1; set_flags(4'b0001);
        step();
        valid_in = 1'b0;
        compared++; if (rf_we !== 1'b1 || rf_wa !== 5'd31 || rf_wd !== 32'hCCCC_DDDD) begin mismatched++; $display("FAIL wrap_lo got %0h/%0h/%0h want 1/1f/ccccdddd", rf_we, rf_wa, rf_wd); end
        step();
        compared++; if (rf_we !== 1'b0 || rf_wa !== 5'd0 || valid_out !== 1'b1) begin mismatched++; $display("FAIL wrap_hi got %0h/%0h/%0h want 0/0/1", rf_we, rf_wa, valid_out); end
        compared++; if (rf_wd !== 32'hAAAA_BBBB) begin mismatched++; $display("FAIL wrap_hi_wd got %0h want aaaabbbb", rf_wd); end
        step();
        compared++; if (stall !== 1'b0 || valid_out !== 1'b0) begin mismatched++; $display("FAIL wrap_idle got %0h/%0h want 0/0", stall, valid_out); end
    endtask

    task automatic test_back_to_back_mul();
        valid_in = 1'b1; FS = 5'b11110; F_mul = 64'h0000_0022_0000_0011; DA = 5'd2; RW = 1'b1; set_flags(4'b0000);
        step();
        F_mul = 64'h0000_0044_0000_0033; DA = 5'd10;
        compared++; if (stall !== 1'b1 || rf_wa !== 5'd2 || rf_wd !== 32'h11) begin mismatched++; $display("FAIL b2b_lo1 got %0h/%0h/%0h want 1/2/11", stall, rf_wa, rf_wd); end
        step();
        compared++; if (stall !== 1'b0 || rf_wa !== 5'd3 || rf_wd !== 32'h22) begin mismatched++; $display("FAIL b2b_hi1 got %0h/%0h/%0h want 0/3/22", stall, rf_wa, rf_wd); end
        step();
        valid_in = 1'b0;
        compared++; if (stall !== 1'b1 || rf_wa !== 5'd10 || rf_wd !== 32'h33) begin mismatched++; $display("FAIL b2b_lo2 got %0h/%0h/%0h want 1/a/33", stall, rf_wa, rf_wd); end
        step();
        compared++; if (rf_wa !== 5'd11 || rf_wd !== 32'h44 || valid_out !== 1'b1) begin mismatched++; $display("FAIL b2b_hi2 got %0h/%0h/%0h want b/44/1", rf_wa, rf_wd, valid_out); end
        step();
        compared++; if (rf_we !== 1'b0 || stall !== 1'b0) begin mismatched++; $display("FAIL b2b_idle got %0h/%0h want 0/0", rf_we, stall); end
    endtask

    task automatic test_reset_in_mul();
        valid_in = 1'b1; FS = 5'b11110; F_mul = 64'h1111_2222_3333_4444; DA = 5'd6; RW = 1'b1; set_flags(4'b1111);
        step();
        valid_in = 1'b0;
        compared++; if (stall !== 1'b1 || rf_wa !== 5'd6) begin mismatched++; $display("FAIL rstmul_lo got %0h/%0h want 1/6", stall, rf_wa); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        compared++; if (rf_we !== 1'b0 || stall !== 1'b0 || psr !== 4'b0000) begin mismatched++; $display("FAIL rstmul_rst got %0h/%0h/%0b want 0/0/0000", rf_we, stall, psr); end
        for (int i = 0; i < 3; i++) begin
            step();
            compared++; if (rf_we !== 1'b0 || valid_out !== 1'b0 || stall !== 1'b0) begin mismatched++; $display("FAIL rstmul_nohi%0d got %0h/%0h/%0h want 0/0/0", i, rf_we, valid_out, stall); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_r0();
        test_slt();
        test_mul_then_add();
        test_mul_wrap();
        test_back_to_back_mul();
        test_reset_in_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
